// File: rtl/word_shift_ser_pkg.sv
// Shared types and helpers for the word shift serializer.
package word_shift_ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    // Counter width able to hold 0..width inclusive.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/word_shift_ser_cnt.sv
// Beat counter: synchronous clear (dominant), increment enable, saturates at WIDTH.
module word_shift_ser_cnt
    import word_shift_ser_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic          last_o
);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CW'(WIDTH))) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/word_shift_serializer.sv
// Parallel-to-serial word shifter with valid/ready handshakes and frame markers.
// Optional trailing even-parity beat when PARITY_EN is defined.
module word_shift_serializer
    import word_shift_ser_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clr,
    input  logic             hold,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_out,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int unsigned CW = cnt_w(WIDTH);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sreg_q, sreg_d;
    logic [WIDTH-1:0]  shifted;
    logic [CW-1:0]     count;
    logic              last;
    logic              data_bit;
    logic              beat;
    logic              load;
    logic              done;
    logic              final_beat;

    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted  = {sreg_q[WIDTH-2:0], 1'b0};
            assign data_bit = sreg_q[WIDTH-1];
        end else begin : g_lsb
            assign shifted  = {1'b0, sreg_q[WIDTH-1:1]};
            assign data_bit = sreg_q[0];
        end
    endgenerate

    assign busy      = (state_q != ST_IDLE);
    // clr also withdraws valid so a dropped word never completes a handshake.
    assign ser_valid = busy & ~hold & ~clr;
    assign beat      = ser_valid & ser_ready;

`ifdef PARITY_EN
    logic parity_q, parity_d;

    assign final_beat = (state_q == ST_PARITY);
    assign ser_out    = final_beat ? parity_q : data_bit;
`else
    assign final_beat = (state_q == ST_SHIFT) & last;
    assign ser_out    = data_bit;
`endif

    assign done        = beat & final_beat;
    assign in_ready    = (state_q == ST_IDLE) ? ~clr : done;
    assign load        = in_valid & in_ready;
    assign frame_start = ser_valid & (state_q == ST_SHIFT) & (count == '0);
    assign frame_end   = ser_valid & final_beat;

    word_shift_ser_cnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr | load | done),
        .en_i    (beat),
        .count_o (count),
        .last_o  (last)
    );

    // Next state: clr > load > beat.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
`ifdef PARITY_EN
        parity_d = parity_q;
`endif
        if (clr) begin
            state_d = ST_IDLE;
            sreg_d  = '0;
        end else if (load) begin
            state_d = ST_SHIFT;
            sreg_d  = in_data;
`ifdef PARITY_EN
            parity_d = ^in_data;
`endif
        end else if (beat) begin
            sreg_d = shifted;
            if (done) begin
                state_d = ST_IDLE;
`ifdef PARITY_EN
            end else if ((state_q == ST_SHIFT) && last) begin
                state_d = ST_PARITY;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
`ifdef PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
`ifdef PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_word_shift_serializer.sv
// Scoreboard bench for word_shift_serializer (WIDTH=16, MSB_FIRST=1).
module tb_word_shift_serializer;

    localparam int W = 16;
`ifdef PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = W + (PAR ? 1 : 0);

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         clr;
    logic         hold;
    logic         ser_valid;
    logic         ser_ready;
    logic         ser_out;
    logic         frame_start;
    logic         frame_end;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    // Expected beat: {bit, frame_start, frame_end}
    logic [2:0] exp_q[$];

    word_shift_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .clr         (clr),
        .hold        (hold),
        .ser_valid   (ser_valid),
        .ser_ready   (ser_ready),
        .ser_out     (ser_out),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [W-1:0] d, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            exp_q.push_back({d[W-1-i], (i == 0), (i == W-1) && !PAR});
        end
        if (PAR && nbeats == W) exp_q.push_back({^d, 1'b0, 1'b1});
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check({name, "_idle"}, int'(busy), 0);
        check({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    // Monitor: every accepted beat is checked against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && ser_valid && ser_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                check("beat", int'({ser_out, frame_start, frame_end}), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int beats;
        logic stall_bit;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; clr = 1'b0; hold = 1'b0; ser_ready = 1'b1;
        #3;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_outputs", int'({ser_valid, ser_out, frame_start, frame_end, busy}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: single word A5C3, full-rate ready
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'hA5C3; push_word(16'hA5C3, W);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            check("t1_contig", int'(ser_valid), 1);
            @(posedge clk); #1;
        end
        wait_idle("t1");

        // 2: back-to-back FFFF then 0001
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'hFFFF; push_word(16'hFFFF, W);
        @(posedge clk); #1;
        in_data = 16'h0001; push_word(16'h0001, W);
        for (int i = 0; i < 2*NB; i++) begin
            @(negedge clk);
            check("t2_contig", int'(ser_valid), 1);
            check("t2_in_ready", int'(in_ready), int'(i == NB-1 || i == 2*NB-1));
            @(posedge clk); #1;
            if (i == NB-1) in_valid = 1'b0;
        end
        wait_idle("t2");

        // 3: ser_ready toggling on 8000
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'h8000; push_word(16'h8000, W);
        @(posedge clk); #1;
        in_valid = 1'b0;
        beats = 0;
        stall_bit = 1'b0;
        for (int c = 0; c < 2*NB; c++) begin
            ser_ready = (c % 2 == 0);
            @(negedge clk);
            if (ser_valid && ser_ready) beats++;
            if (c % 2 == 1) stall_bit = ser_out;
            else if (c > 0) check("t3_stall_stable", int'(ser_out), int'(stall_bit));
            @(posedge clk); #1;
        end
        ser_ready = 1'b1;
        check("t3_beats", beats, NB);
        wait_idle("t3");

        // 4: hold for 3 cycles after beat 5
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'hC3A5; push_word(16'hC3A5, W);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'h5555;
        repeat (6) @(posedge clk);
        #1 hold = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t4_hold_valid", int'(ser_valid), 0);
            check("t4_hold_in_ready", int'(in_ready), 0);
            check("t4_hold_busy", int'(busy), 1);
            @(posedge clk); #1;
        end
        hold = 1'b0; in_valid = 1'b0;
        wait_idle("t4");

        // 5: clr at beat 8 with in_valid on the same cycle
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'hF0F0; push_word(16'hF0F0, 8);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 clr = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
        @(negedge clk);
        check("t5_clr_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("t5_busy", int'(busy), 0);
        check("t5_ser_valid", int'(ser_valid), 0);
        check("t5_in_ready", int'(in_ready), 1);
        check("t5_sb_empty", exp_q.size(), 0);

        // 6: word 0007 (parity beat 1 when PARITY_EN)
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'h0007; push_word(16'h0007, W);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            check("t6_contig", int'(ser_valid), 1);
            @(posedge clk); #1;
        end
        wait_idle("t6");

        // 7: async reset mid-word at beat 4
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'hFFFF; push_word(16'hFFFF, 4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t7_pre_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("t7_rst_outputs", int'({ser_valid, ser_out, frame_start, frame_end, busy}), 0);
        check("t7_rst_in_ready", int'(in_ready), 1);
        check("t7_sb_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t7_after_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
